async_fifo_rd_arb: RTL
======================

ASYNC_FIFO_RD_ARB -- requirements
Module: async_fifo_rd_arb

Interface
REQ-001 Parameter NUM_SRC, default 4, number of async FIFO read ports arbitrated (2..8).
REQ-002 Parameter DAT_BIT, default 32, data width per FIFO.
REQ-003 Parameter BURST_MAX, default 8, max consecutive reads per grant (1..16).
REQ-004 rd_clk  input  1  sole clock; all logic on rising edge.
REQ-005 rd_rst  input  1  reset, synchronous, active-high.
REQ-006 rd_empty  input  NUM_SRC  per-FIFO empty flag, registered, rd_clk domain.
REQ-007 rd_data  input  NUM_SRC*DAT_BIT  packed FIFO read data, source i at bits [i*DAT_BIT +: DAT_BIT], valid one cycle after an accepted read.
REQ-008 rd_req  output  NUM_SRC  per-FIFO read request, one-hot or zero.
REQ-009 out_valid  output  1  output word available.
REQ-010 out_ready  input  1  downstream accepts word when high with out_valid.
REQ-011 out_data  output  DAT_BIT  output word.
REQ-012 out_src  output  clog2(NUM_SRC)  source index of out_data.
REQ-013 busy  output  1  high in state BURST or when any read is in flight.

Function
REQ-014 Accepted read: cycle where rd_req[g] && !rd_empty[g]; rd_req to an empty FIFO is not counted.
REQ-015 Read latency fixed at 1: rd_data slice g captured with tag g on the cycle after an accepted read.
REQ-016 Output buffer: 2-entry FIFO of {src, data}; out_valid = not empty; head presented on out_data/out_src; pop on out_valid && out_ready.
REQ-017 Credit rule: rd_req asserted only when (buffer occupancy + in-flight reads) < 2, evaluated with same-cycle pop counted as freed; buffer never overflows.
REQ-018 FSM states IDLE, BURST.
REQ-019 IDLE: if any rd_empty bit low and credit available, grant g = first non-empty index searched from last_grant+1 wrapping modulo NUM_SRC, load burst count 0, go BURST next cycle; rd_req zero in IDLE.
REQ-020 BURST: rd_req[g] = !rd_empty[g] && credit; burst count increments per accepted read.
REQ-021 BURST exit to IDLE when burst count reaches BURST_MAX on an accepted read, or rd_empty[g] high; last_grant <= g on exit.
REQ-022 Credit stall in BURST holds grant; rd_req deasserted; no exit.
REQ-023 Round-robin fairness: with all sources continuously non-empty, grants rotate 0,1,..,NUM_SRC-1,0.
REQ-024 Ordering: output words appear in accepted-read order; never reordered or dropped.
REQ-025 Single source non-empty: same source regranted after one IDLE cycle.

Reset
REQ-026 On rd_rst high at a clock edge: state IDLE, last_grant = NUM_SRC-1, burst count 0, buffer emptied, in-flight flag cleared.
REQ-027 Reset values: rd_req 0, out_valid 0, out_data 0, out_src 0, busy 0.
REQ-028 Reset mid-burst discards in-flight and buffered words; rd_data on the following cycle ignored.

Configuration
REQ-029 Macro ASYNC_FIFO_ARB_BURST_EN: defined -> grant held up to BURST_MAX reads per REQ-021; undefined -> BURST_MAX ignored, exit after every accepted read (burst length 1, re-arbitrate per word).

Verification
REQ-030 All 4 FIFOs non-empty with 20 words each, out_ready=1, macro defined -> out_src sequence 0x8,1x8,2x8,3x8,0x8...; all 80 words in per-source order.
REQ-031 Only FIFO 2 non-empty with 3 words -> 3 reads from src 2, then rd_empty[2] high -> IDLE, rd_req stays 0.
REQ-032 out_ready=0 for 10 cycles during burst -> exactly 2 words buffered, rd_req low, no loss; release -> stream resumes in order.
REQ-033 rd_rst pulsed mid-burst with 1 word buffered -> next cycle out_valid=0, rd_req=0, state IDLE; post-reset first grant to src 0.
REQ-034 Macro undefined, FIFOs 0 and 1 non-empty -> out_src alternates 0,1,0,1.
REQ-035 rd_empty[g] rises in same cycle rd_req[g] asserted -> no read counted, no word captured, exit to IDLE.

Source files
------------

// File: rtl/async_fifo_rd_arb_if.sv
// Handshake bundle between the read arbiter and its FIFO read ports / downstream sink.
interface async_fifo_rd_arb_if #(
    parameter int NUM_SRC = 4,
    parameter int DAT_BIT = 32
);
    localparam int SRC_BIT = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0]         rd_empty;
    logic [NUM_SRC*DAT_BIT-1:0] rd_data;
    logic [NUM_SRC-1:0]         rd_req;
    logic                       out_valid;
    logic                       out_ready;
    logic [DAT_BIT-1:0]         out_data;
    logic [SRC_BIT-1:0]         out_src;
    logic                       busy;

    modport slave (
        input  rd_empty, rd_data, out_ready,
        output rd_req, out_valid, out_data, out_src, busy
    );

    modport master (
        output rd_empty, rd_data, out_ready,
        input  rd_req, out_valid, out_data, out_src, busy
    );
endinterface

// File: rtl/async_fifo_rd_arb.sv
// Round-robin burst arbiter draining NUM_SRC FIFO read ports into one stream; ASYNC_FIFO_ARB_BURST_EN enables multi-word bursts.
// Latency: read accepted at cycle n, word enters the 2-entry output buffer at n+1, visible on out_* at n+2.
// Backpressure: reads are issued only while buffer occupancy plus in-flight reads stays below 2.
module async_fifo_rd_arb #(
    parameter int NUM_SRC   = 4,
    parameter int DAT_BIT   = 32,
    parameter int BURST_MAX = 8
) (
    input  logic                 rd_clk,
    input  logic                 rd_rst,
    async_fifo_rd_arb_if.slave   bus
);
    localparam int SRC_BIT = $clog2(NUM_SRC);
    localparam int CNT_BIT = $clog2(BURST_MAX + 1);
    localparam int ENT_BIT = SRC_BIT + DAT_BIT;

`ifdef ASYNC_FIFO_ARB_BURST_EN
    localparam logic [CNT_BIT-1:0] BURST_LIM = CNT_BIT'(BURST_MAX);
`else
    localparam logic [CNT_BIT-1:0] BURST_LIM = CNT_BIT'(1);
`endif

    typedef enum logic {IDLE, BURST} state_t;

    state_t              state_q;
    logic [SRC_BIT-1:0]  grant_q;
    logic [SRC_BIT-1:0]  last_grant_q;
    logic [SRC_BIT-1:0]  next_grant;
    logic [CNT_BIT-1:0]  burst_cnt_q;
    logic                inflight_q;
    logic [SRC_BIT-1:0]  inflight_src_q;

    logic [ENT_BIT-1:0]  buf_q [2];
    logic                wr_ptr_q;
    logic                rd_ptr_q;
    logic [1:0]          cnt_q;

    logic                pop;
    logic                credit;
    logic                any_ready;
    logic                accepted;
    logic [NUM_SRC-1:0]  rd_req;

    assign pop       = (cnt_q != 2'd0) && bus.out_ready;
    // A same-cycle pop frees its slot before the new read is counted.
    assign credit    = (({1'b0, cnt_q} + {2'b00, inflight_q}) - {2'b00, pop}) < 3'd2;
    assign any_ready = |(~bus.rd_empty);

    always_comb begin
        next_grant = last_grant_q;
        for (int k = NUM_SRC; k >= 1; k--) begin
            int                 t;
            logic [SRC_BIT-1:0] idx;
            t = int'(last_grant_q) + k;
            if (t >= NUM_SRC) begin
                t = t - NUM_SRC;
            end
            idx = SRC_BIT'(t);
            if (!bus.rd_empty[idx]) begin
                next_grant = idx;
            end
        end
    end

    always_comb begin
        rd_req = '0;
        if (state_q == BURST && credit && !bus.rd_empty[grant_q]) begin
            rd_req[grant_q] = 1'b1;
        end
    end

    assign accepted   = |(rd_req & ~bus.rd_empty);
    assign bus.rd_req = rd_req;
    assign bus.busy   = (state_q == BURST) || inflight_q;

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_q        <= IDLE;
            grant_q        <= '0;
            last_grant_q   <= SRC_BIT'(NUM_SRC - 1);
            burst_cnt_q    <= '0;
            inflight_q     <= 1'b0;
            inflight_src_q <= '0;
        end else begin
            inflight_q     <= accepted;
            inflight_src_q <= grant_q;
            case (state_q)
                IDLE: begin
                    if (any_ready && credit) begin
                        grant_q     <= next_grant;
                        burst_cnt_q <= '0;
                        state_q     <= BURST;
                    end
                end
                BURST: begin
                    if (accepted) begin
                        burst_cnt_q <= burst_cnt_q + CNT_BIT'(1);
                        if ((burst_cnt_q + CNT_BIT'(1)) == BURST_LIM) begin
                            state_q      <= IDLE;
                            last_grant_q <= grant_q;
                        end
                    end else if (bus.rd_empty[grant_q]) begin
                        state_q      <= IDLE;
                        last_grant_q <= grant_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output buffer; credit accounting guarantees a free slot whenever a word lands.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (inflight_q) begin
                buf_q[wr_ptr_q] <= {inflight_src_q, bus.rd_data[inflight_src_q*DAT_BIT +: DAT_BIT]};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= (cnt_q + {1'b0, inflight_q}) - {1'b0, pop};
        end
    end

    assign bus.out_valid = (cnt_q != 2'd0);
    assign bus.out_data  = buf_q[rd_ptr_q][DAT_BIT-1:0];
    assign bus.out_src   = buf_q[rd_ptr_q][ENT_BIT-1 -: SRC_BIT];

endmodule
